// File: rtl/instr_register_seq_if.sv
// Interface for instr_register_seq: write handshake, operands, read port and commit pulse.
// Optional INSTR_REG_PARITY_EN adds rd_parity_err.
interface instr_register_seq_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
);
    localparam int AW    = $clog2(DEPTH);
    localparam int RES_W = 2 * DATA_W;

    logic              load_valid;
    logic              load_ready;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [AW-1:0]     write_pointer;
    logic [AW-1:0]     read_pointer;
    logic [2:0]        rd_opcode;
    logic [DATA_W-1:0] rd_operand_a;
    logic [DATA_W-1:0] rd_operand_b;
    logic [RES_W-1:0]  rd_result;
    logic              rd_err;
    logic              wr_done;
`ifdef INSTR_REG_PARITY_EN
    logic              rd_parity_err;
`endif

    modport master (
        output load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  load_ready, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err, wr_done
`ifdef INSTR_REG_PARITY_EN
        , rd_parity_err
`endif
    );

    modport slave (
        input  load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output load_ready, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err, wr_done
`ifdef INSTR_REG_PARITY_EN
        , rd_parity_err
`endif
    );
endinterface

// File: rtl/instr_register_seq.sv
// Instruction register with in-block ALU and iterative restoring divider.
// Define INSTR_REG_PARITY_EN to add per-entry even parity and rd_parity_err.
module instr_register_seq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input logic                 clk,
    input logic                 reset,
    instr_register_seq_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int RES_W = 2 * DATA_W;
    localparam int CW    = $clog2(DATA_W);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    typedef enum logic [1:0] {IDLE, DIV_RUN, WRITE} state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [RES_W-1:0]  res;
        logic              err;
    } word_t;

    localparam int WORD_W = $bits(word_t);
`ifdef INSTR_REG_PARITY_EN
    localparam int ENTRY_W = WORD_W + 1;
`else
    localparam int ENTRY_W = WORD_W;
`endif

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d;

    logic              accept, commit;
    logic [DATA_W:0]   shifted, diff;
    logic [RES_W-1:0]  a_ext, b_ext, q_ext, r_ext;
    logic [RES_W-1:0]  commit_res;
    logic              commit_err;
    word_t             commit_word;
    logic [ENTRY_W-1:0] entry_w;
    logic [ENTRY_W-1:0] mem_rd [DEPTH];
    logic [ENTRY_W-1:0] rd_entry_d;
    word_t             rd_word_q, rd_word_d;

    // Ready and commit are masked by reset so nothing is accepted or written in the reset cycle.
    assign bus.load_ready = !reset && (state_q != DIV_RUN);
    assign bus.wr_done    = !reset && (state_q == WRITE);
    assign accept         = bus.load_valid && bus.load_ready;
    assign commit         = bus.wr_done;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, mag(b_q)};
        case (state_q)
            DIV_RUN: begin
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) state_d = WRITE;
            end
            WRITE:   state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            op_d   = bus.opcode;
            a_d    = bus.operand_a;
            b_d    = bus.operand_b;
            wptr_d = bus.write_pointer;
            if ((bus.opcode == OP_DIV || bus.opcode == OP_MOD) && bus.operand_b != '0) begin
                state_d = DIV_RUN;
                quo_d   = mag(bus.operand_a);
                rem_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = WRITE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    // Divider works on magnitudes; signs are applied here from the captured operands.
    always_comb begin
        a_ext      = {{DATA_W{a_q[DATA_W-1]}}, a_q};
        b_ext      = {{DATA_W{b_q[DATA_W-1]}}, b_q};
        q_ext      = {{DATA_W{1'b0}}, quo_q};
        r_ext      = {{DATA_W{1'b0}}, rem_q};
        commit_res = '0;
        commit_err = 1'b0;
        case (op_q)
            OP_ZERO:  commit_res = '0;
            OP_PASSA: commit_res = a_ext;
            OP_PASSB: commit_res = b_ext;
            OP_ADD:   commit_res = a_ext + b_ext;
            OP_SUB:   commit_res = a_ext - b_ext;
            OP_MULT:  commit_res = a_ext * b_ext;
            OP_DIV: begin
                if (b_q == '0) commit_err = 1'b1;
                else commit_res = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -q_ext : q_ext;
            end
            OP_MOD: begin
                if (b_q == '0) commit_err = 1'b1;
                else commit_res = a_q[DATA_W-1] ? -r_ext : r_ext;
            end
            default: ;
        endcase
        commit_word = '{op: op_q, a: a_q, b: b_q, res: commit_res, err: commit_err};
    end

`ifdef INSTR_REG_PARITY_EN
    assign entry_w = {^commit_word, commit_word};
`else
    assign entry_w = commit_word;
`endif

    // Entries must clear on reset, so storage is per-entry flops rather than a RAM.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_q;
            always_ff @(posedge clk) begin
                if (reset) entry_q <= '0;
                else if (commit && wptr_q == AW'(gi)) entry_q <= entry_w;
            end
            assign mem_rd[gi] = entry_q;
        end
    endgenerate

    assign rd_entry_d = (commit && wptr_q == bus.read_pointer) ? entry_w : mem_rd[bus.read_pointer];
    assign rd_word_d  = word_t'(rd_entry_d[WORD_W-1:0]);

    always_ff @(posedge clk) begin
        if (reset) rd_word_q <= '0;
        else       rd_word_q <= rd_word_d;
    end

    assign bus.rd_opcode    = rd_word_q.op;
    assign bus.rd_operand_a = rd_word_q.a;
    assign bus.rd_operand_b = rd_word_q.b;
    assign bus.rd_result    = rd_word_q.res;
    assign bus.rd_err       = rd_word_q.err;

`ifdef INSTR_REG_PARITY_EN
    logic rd_parity_err_q;
    always_ff @(posedge clk) begin
        if (reset) rd_parity_err_q <= 1'b0;
        else       rd_parity_err_q <= ^rd_entry_d;
    end
    assign bus.rd_parity_err = rd_parity_err_q;
`endif
endmodule

// File: tb/tb_instr_register_seq.sv
// Directed self-checking bench for instr_register_seq with hand-computed expected values.
module tb_instr_register_seq;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_register_seq_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    instr_register_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [4:0] ptr);
        bus.load_valid    = 1'b1;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.write_pointer = ptr;
        $display("write op=%0d a=0x%0h b=0x%0h ptr=%0d", op, a, b, ptr);
    endtask

    task automatic read_check(input string tag, input logic [4:0] ptr,
                              input logic [63:0] exp_res, input logic exp_err);
        bus.read_pointer = ptr;
        tick();
        $display("read ptr=%0d result=0x%0h err=%0b", ptr, bus.rd_result, bus.rd_err);
        check_eq({tag, "_res"}, bus.rd_result, exp_res);
        check_eq({tag, "_err"}, bus.rd_err, exp_err);
`ifdef INSTR_REG_PARITY_EN
        check_eq({tag, "_par"}, bus.rd_parity_err, 1'b0);
`endif
    endtask

    task automatic div_run(input string tag, input logic [2:0] op, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [4:0] ptr);
        int low;
        drive_op(op, a, b, ptr);
        tick();
        bus.load_valid = 1'b0;
        low = 0;
        while (bus.load_ready !== 1'b1 && low < 100) begin
            low++;
            tick();
        end
        check_eq({tag, "_ready_low"}, low, 32);
        check_eq({tag, "_wr_done"}, bus.wr_done, 1'b1);
        tick();
    endtask

    logic [2:0]        v_op [3] = '{3'd3, 3'd4, 3'd5};
    logic [DATA_W-1:0] v_a  [3] = '{32'd5, 32'd5, 32'hFFFF_FFF9};
    logic [DATA_W-1:0] v_b  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd6};

    initial begin
        int hits;
        bus.load_valid    = 1'b0;
        bus.opcode        = '0;
        bus.operand_a     = '0;
        bus.operand_b     = '0;
        bus.write_pointer = '0;
        bus.read_pointer  = '0;
        reset             = 1'b1;

        tick();
        check_eq("rst_ready", bus.load_ready, 1'b0);
        check_eq("rst_wr_done", bus.wr_done, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("ready_after_rst", bus.load_ready, 1'b1);

        for (int i = 0; i < DEPTH; i++) begin
            bus.read_pointer = i[4:0];
            tick();
            check_eq("rst_rd_res", bus.rd_result, 64'd0);
            check_eq("rst_rd_fields", {bus.rd_opcode, bus.rd_err, bus.rd_operand_a, bus.rd_operand_b}, '0);
        end

        for (int i = 0; i < 3; i++) begin
            drive_op(v_op[i], v_a[i], v_b[i], 5'(i + 1));
            tick();
            check_eq("b2b_wr_done", bus.wr_done, 1'b1);
        end
        bus.load_valid = 1'b0;
        tick();
        check_eq("b2b_wr_done_end", bus.wr_done, 1'b0);
        read_check("add", 5'd1, 64'd2, 1'b0);
        read_check("sub", 5'd2, 64'd8, 1'b0);
        read_check("mult", 5'd3, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        check_eq("mult_opa", bus.rd_operand_a, 32'hFFFF_FFF9);
        check_eq("mult_opc", bus.rd_opcode, 3'd5);

        div_run("div", 3'd6, 32'hFFFF_FFEF, 32'd5, 5'd4);
        div_run("mod", 3'd7, 32'hFFFF_FFEF, 32'd5, 5'd5);
        read_check("div", 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        read_check("mod", 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

        drive_op(3'd6, 32'd9, 32'd0, 5'd6);
        tick();
        check_eq("div0_wr_done", bus.wr_done, 1'b1);
        check_eq("div0_ready", bus.load_ready, 1'b1);
        bus.load_valid = 1'b0;
        tick();
        read_check("div0", 5'd6, 64'd0, 1'b1);
        check_eq("div0_opc", bus.rd_opcode, 3'd6);

        div_run("divneg", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        read_check("divneg", 5'd8, 64'h0000_0000_8000_0000, 1'b0);

        bus.read_pointer = 5'd7;
        drive_op(3'd1, 32'h1234, 32'd0, 5'd7);
        tick();
        check_eq("byp_pre", bus.rd_result, 64'd0);
        bus.load_valid = 1'b0;
        tick();
        check_eq("bypass", bus.rd_result, 64'h1234);
        drive_op(3'd2, 32'h999, 32'h55, 5'd7);
        tick();
        bus.load_valid = 1'b0;
        tick();
        check_eq("overwrite_res", bus.rd_result, 64'h55);
        check_eq("overwrite_opc", bus.rd_opcode, 3'd2);

        drive_op(3'd6, 32'd100, 32'd7, 5'd9);
        tick();
        bus.load_valid = 1'b0;
        repeat (10) tick();
        check_eq("mid_div_busy", bus.load_ready, 1'b0);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_ready", bus.load_ready, 1'b0);
        check_eq("mid_rst_wr_done", bus.wr_done, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_ready_after", bus.load_ready, 1'b1);
        hits = 0;
        repeat (40) begin
            tick();
            if (bus.wr_done) hits++;
        end
        check_eq("mid_rst_no_commit", hits, 0);
        read_check("rst_div", 5'd9, 64'd0, 1'b0);
        check_eq("rst_div_opc", bus.rd_opcode, 3'd0);
        read_check("rst_clr", 5'd1, 64'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
